// File: rtl/image_loader_pkg.sv
// Shared definitions for the median-filter front end.
//   - Default frame dimensions, also used by filteringModule.
//   - Loader FSM state encodings.
package image_loader_pkg;

    localparam int DEF_IMAGE_WIDTH  = 240;
    localparam int DEF_IMAGE_HEIGHT = 180;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD        = 2'd1,
        KICK        = 2'd2,
        WAIT_FILTER = 2'd3
    } loaderState_t;

endpackage

// File: rtl/image_loader_raster_counter.sv
// raster_counter: raster-order x/y write position for the image loader.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset, clears x/y
//   advance   in   step to the next pixel position
//   x         out  current column (0..IMAGE_WIDTH-1)
//   y         out  current row (0..IMAGE_HEIGHT-1)
//   frameLast out  position is the last pixel of the frame
module raster_counter
    import image_loader_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       frameLast
);

    localparam logic [7:0] X_LAST = 8'(IMAGE_WIDTH - 1);
    localparam logic [7:0] Y_LAST = 8'(IMAGE_HEIGHT - 1);

    logic lineLast;

    assign lineLast  = (x == X_LAST);
    assign frameLast = lineLast && (y == Y_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (advance) begin
            if (lineLast) begin
                x <= 8'd0;
                y <= frameLast ? 8'd0 : y + 8'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

endmodule

// File: rtl/image_loader.sv
// image_loader: binarises a raster-order 8-bit pixel stream into the 1-bit
// frame memory read by filteringModule, then hands the frame over with a
// one-cycle start pulse and waits for filterDone before loading again.
// Optional feature macro: LOADER_DYN_THRESH_EN adds a runtime threshold port
// sampled at every accepted pixel; otherwise parameter THRESHOLD is used.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   loadEnable                 permits starting a frame
//   pixelValid/pixelReady      pixel handshake (pixelReady = state LOAD)
//   pixelData                  grayscale pixel
//   threshold                  runtime threshold (LOADER_DYN_THRESH_EN only)
//   filterReady, filterDone    filteringModule status
//   start                      registered one-cycle kick to filteringModule
//   memWriteEnable, memXAddress, memYAddress, memData   frame-memory write
//   frameCount                 frames handed to the filter (wraps)
//   busy                       loader not idle
module image_loader
    import image_loader_pkg::*;
#(
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int THRESHOLD    = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadEnable,
    input  logic       pixelValid,
    input  logic [7:0] pixelData,
    output logic       pixelReady,
`ifdef LOADER_DYN_THRESH_EN
    input  logic [7:0] threshold,
`endif
    input  logic       filterReady,
    input  logic       filterDone,
    output logic       start,
    output logic       memWriteEnable,
    output logic [7:0] memXAddress,
    output logic [7:0] memYAddress,
    output logic       memData,
    output logic [7:0] frameCount,
    output logic       busy
);

    loaderState_t state, nextState;
    logic         accept;
    logic [7:0]   xPos, yPos;
    logic         frameLast;
    logic [7:0]   thr;

    function automatic logic binarise(input logic [7:0] pix, input logic [7:0] level);
        return (pix >= level);
    endfunction

`ifdef LOADER_DYN_THRESH_EN
    assign thr = threshold;
`else
    assign thr = 8'(THRESHOLD);
`endif

    assign pixelReady = (state == LOAD);
    assign accept     = pixelValid && pixelReady;
    assign busy       = (state != IDLE);

    raster_counter #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT)
    ) u_rasterCounter (
        .clk      (clk),
        .reset    (reset),
        .advance  (accept),
        .x        (xPos),
        .y        (yPos),
        .frameLast(frameLast)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // filterDone is only honoured after the start cycle, so a done flag left
    // over from the previous frame cannot release the loader early.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:        if (loadEnable) nextState = LOAD;
            LOAD:        if (accept && frameLast) nextState = KICK;
            KICK:        if (filterReady) nextState = WAIT_FILTER;
            WAIT_FILTER: if (filterDone && !start) nextState = loadEnable ? LOAD : IDLE;
            default:     nextState = IDLE;
        endcase
    end

    // Handover stage: start and frameCount update on the KICK -> WAIT_FILTER edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start      <= 1'b0;
            frameCount <= 8'd0;
        end else begin
            start <= (state == KICK) && filterReady;
            if ((state == KICK) && filterReady) begin
                frameCount <= frameCount + 8'd1;
            end
        end
    end

    // Write stage: one cycle after accept; address/data hold between writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memWriteEnable <= 1'b0;
            memXAddress    <= 8'd0;
            memYAddress    <= 8'd0;
            memData        <= 1'b0;
        end else begin
            memWriteEnable <= accept;
            if (accept) begin
                memXAddress <= xPos;
                memYAddress <= yPos;
                memData     <= binarise(pixelData, thr);
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed testbench for image_loader with a 4x3 frame.
module tb_image_loader;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       loadEnable = 1'b0;
    logic       pixelValid = 1'b0;
    logic [7:0] pixelData = 8'd0;
    logic       filterReady = 1'b0;
    logic       filterDone = 1'b0;
`ifdef LOADER_DYN_THRESH_EN
    logic [7:0] threshold = 8'd128;
`endif
    logic       pixelReady;
    logic       start;
    logic       memWriteEnable;
    logic [7:0] memXAddress;
    logic [7:0] memYAddress;
    logic       memData;
    logic [7:0] frameCount;
    logic       busy;

    image_loader #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .THRESHOLD   (128)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .loadEnable    (loadEnable),
        .pixelValid    (pixelValid),
        .pixelData     (pixelData),
        .pixelReady    (pixelReady),
`ifdef LOADER_DYN_THRESH_EN
        .threshold     (threshold),
`endif
        .filterReady   (filterReady),
        .filterDone    (filterDone),
        .start         (start),
        .memWriteEnable(memWriteEnable),
        .memXAddress   (memXAddress),
        .memYAddress   (memYAddress),
        .memData       (memData),
        .frameCount    (frameCount),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int startCnt = 0;
    int startCyc = 0;
    int lastAccCyc = 0;
    logic [16:0] wrQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (memWriteEnable) wrQ.push_back({memXAddress, memYAddress, memData});
        if (start) begin
            startCnt = startCnt + 1;
            startCyc = cyc;
        end
        if (pixelValid && pixelReady) lastAccCyc = cyc;
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sendPixel(input logic [7:0] v, input bit gap);
        bit ok;
        ok = 1'b0;
        if (gap) begin
            pixelValid = 1'b0;
            @(posedge clk); #1;
        end
        pixelValid = 1'b1;
        pixelData  = v;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (pixelReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkEq("acceptTimeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] pix[12], input logic expD[12]);
        logic [16:0] e;
        checkEq({tag, "_writes"}, wrQ.size(), 12);
        for (int i = 0; i < 12 && i < wrQ.size(); i++) begin
            e = {8'(i % W), 8'(i / W), expD[i]};
            checkEq($sformatf("%s_w%0d_px%0h", tag, i, pix[i]), wrQ[i], e);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_start"}, start, 0);
        checkEq({tag, "_we"}, memWriteEnable, 0);
        checkEq({tag, "_x"}, memXAddress, 0);
        checkEq({tag, "_y"}, memYAddress, 0);
        checkEq({tag, "_data"}, memData, 0);
        checkEq({tag, "_frames"}, frameCount, 0);
        checkEq({tag, "_busy"}, busy, 0);
        checkEq({tag, "_ready"}, pixelReady, 0);
    endtask

    logic [7:0] p1[12] = '{8'd0, 8'd127, 8'd128, 8'd255, 8'd1, 8'd200,
                           8'd129, 8'd64, 8'd128, 8'd127, 8'd250, 8'd3};
    logic       d1[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                           1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] p2[12] = '{8'd10, 8'd128, 8'd127, 8'd129, 8'd255, 8'd0,
                           8'd130, 8'd126, 8'd200, 8'd50, 8'd128, 8'd90};
    logic       d2[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                           1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pa, pb;
        logic       da, db;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        checkEq("idle_busy", busy, 0);
        checkEq("idle_ready", pixelReady, 0);

        // Full frame, streaming, filter ready
        loadEnable  = 1'b1;
        filterReady = 1'b1;
        wrQ.delete();
        for (int i = 0; i < 12; i++) sendPixel(p1[i], 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkFrame("frame1", p1, d1);
        checkEq("frame1_startCnt", startCnt, 1);
        checkEq("frame1_startLatency", startCyc - lastAccCyc, 2);
        checkEq("frame1_frameCount", frameCount, 1);
        checkEq("wait_busy", busy, 1);
        checkEq("wait_readyLow", pixelReady, 0);
        checkEq("wait_noWrite", memWriteEnable, 0);

        // filterDone with loadEnable low returns to idle
        filterDone = 1'b1;
        loadEnable = 1'b0;
        @(posedge clk); #1;
        filterDone = 1'b0;
        checkEq("done_idle_busy", busy, 0);
        checkEq("done_idle_ready", pixelReady, 0);

        // Backpressure frame with filter busy at completion
        loadEnable  = 1'b1;
        filterReady = 1'b0;
        wrQ.delete();
        for (int i = 0; i < 12; i++) sendPixel(p2[i], 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checkFrame("frame2", p2, d2);
        checkEq("kick_startCnt", startCnt, 1);
        checkEq("kick_start", start, 0);
        checkEq("kick_busy", busy, 1);
        checkEq("kick_readyLow", pixelReady, 0);
        checkEq("kick_frameCount", frameCount, 1);
        pixelValid  = 1'b0;
        filterReady = 1'b1;
        @(posedge clk); #1;
        checkEq("kick_startPulse", start, 1);
        checkEq("kick_frameCount2", frameCount, 2);
        filterDone = 1'b1;
        loadEnable = 1'b0;
        @(posedge clk); #1;
        checkEq("doneIgnored_start", start, 0);
        checkEq("doneIgnored_busy", busy, 1);
        @(posedge clk); #1;
        filterDone = 1'b0;
        checkEq("doneHonoured_busy", busy, 0);
        checkEq("frame2_startCnt", startCnt, 2);

        // filterDone with loadEnable high goes straight back to LOAD
        loadEnable = 1'b1;
        wrQ.delete();
        for (int i = 0; i < 12; i++) sendPixel(p1[i], 1'b0);
        pixelValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkEq("frame3_writes", wrQ.size(), 12);
        checkEq("frame3_frameCount", frameCount, 3);
        filterDone = 1'b1;
        @(posedge clk); #1;
        filterDone = 1'b0;
        checkEq("reload_ready", pixelReady, 1);
        checkEq("reload_busy", busy, 1);
        wrQ.delete();
        sendPixel(8'hFF, 1'b0);
        pixelValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("reload_writes", wrQ.size(), 1);
        if (wrQ.size() > 0) checkEq("reload_first", wrQ[0], {8'd0, 8'd0, 1'b1});

        // Reset mid-frame after 5 pixels
        for (int i = 0; i < 4; i++) sendPixel(8'h90, 1'b0);
        pixelValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("midReset");
        @(posedge clk); #1;
        reset = 1'b1;
`ifdef LOADER_DYN_THRESH_EN
        threshold = 8'h40;
        pa = 8'h40; da = 1'b1;
        pb = 8'h3F; db = 1'b0;
`else
        pa = 8'h80; da = 1'b1;
        pb = 8'h7F; db = 1'b0;
`endif
        wrQ.delete();
        sendPixel(pa, 1'b0);
        sendPixel(pb, 1'b0);
        pixelValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkEq("afterReset_writes", wrQ.size(), 2);
        if (wrQ.size() > 1) begin
            checkEq("afterReset_first", wrQ[0], {8'd0, 8'd0, da});
            checkEq("afterReset_second", wrQ[1], {8'd1, 8'd0, db});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
